muldiv_unit: RTL

- Iterative multiply/divide unit implementing the RV32M operations. It is the multi-cycle companion to the single-cycle ALU in the execute stage.
- Operands and operation are accepted on a valid/ready handshake. The result is held on a second valid/ready handshake until the core consumes it.
- Width is parametrised by XLEN. The result carries the same Zero/Negative flags the ALU produces.

---
 rtl/muldiv_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready on both sides.
// Multiply is shift-add and divide is restoring, with one bit per cycle.
// Optional build macro MULDIV_FLUSH_EN adds the synchronous Flush (kill) input.
//
// state | meaning
// IDLE  | ready for a request; start_q marks the one-cycle setup after acceptance
// CALC  | XLEN iterations on operand magnitudes; sign fix-up on the last one
// DONE  | Result presented and held until OutReady
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      MDOp,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            Negative,
`ifdef MULDIV_FLUSH_EN
  input  logic            Flush,
`endif
  output logic            Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t                state_q, state_d;
  logic                  start_q, start_d;
  logic [2:0]            op_q, op_d;
  logic [XLEN-1:0]       a_q, a_d;
  logic [XLEN-1:0]       b_q, b_d;
  logic [XLEN-1:0]       opd_q, opd_d;
  logic [2*XLEN-1:0]     prod_q, prod_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       result_q, result_d;

  logic                  flush;
  logic                  is_div, is_rem, a_signed, b_signed;
  logic                  a_neg, b_neg;
  logic [XLEN-1:0]       mag_a, mag_b;
  logic                  div_zero, div_ovf;
  logic [XLEN-1:0]       special_res;
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_next;
  logic [XLEN:0]         rem_sh;
  logic                  rem_ge;
  logic [XLEN-1:0]       rem_sub;
  logic [2*XLEN-1:0]     div_next;
  logic [2*XLEN-1:0]     step_next;
  logic [2*XLEN-1:0]     prod_neg;
  logic [2*XLEN-1:0]     mul_fin;
  logic [XLEN-1:0]       mul_res;
  logic [XLEN-1:0]       div_val;
  logic [XLEN-1:0]       div_res;
  logic [XLEN-1:0]       final_res;

`ifdef MULDIV_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  // Operand classification and magnitudes, from the latched request
  always_comb begin
    is_div   = op_q[2];
    is_rem   = op_q[2] & op_q[1];
    a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
               (op_q == OP_DIV)  || (op_q == OP_REM);
    b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    a_neg    = a_signed & a_q[XLEN-1];
    b_neg    = b_signed & b_q[XLEN-1];
    mag_a    = a_neg ? (~a_q + XLEN'(1)) : a_q;
    mag_b    = b_neg ? (~b_q + XLEN'(1)) : b_q;
    div_zero = is_div && (b_q == '0);
    // Most-negative / -1 only overflows for the signed divide pair
    div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
               (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    if (div_zero)
      special_res = is_rem ? a_q : '1;
    else
      special_res = is_rem ? '0 : a_q;
  end

  // One iteration of shift-add multiply or restoring divide on prod_q
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
    mul_next = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]}
                         : {1'b0, prod_q[2*XLEN-1:1]};
    // Partial remainder always stays below the divisor, so the shifted
    // value needs one extra bit and the difference fits back in XLEN bits.
    rem_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    rem_ge   = rem_sh >= {1'b0, opd_q};
    rem_sub  = rem_sh[XLEN-1:0] - opd_q;
    div_next = rem_ge ? {rem_sub, prod_q[XLEN-2:0], 1'b1}
                      : {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    step_next = is_div ? div_next : mul_next;
  end

  // Sign fix-up and result selection applied to the last iteration
  always_comb begin
    prod_neg  = ~step_next + (2*XLEN)'(1);
    mul_fin   = neg_q ? prod_neg : step_next;
    mul_res   = (op_q == OP_MUL) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
    div_val   = is_rem ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
    div_res   = neg_q ? (~div_val + XLEN'(1)) : div_val;
    final_res = is_div ? div_res : mul_res;
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opd_d    = opd_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          start_d = 1'b0;
        end else if (start_q) begin
          start_d = 1'b0;
          neg_d   = is_rem ? a_neg : (a_neg ^ b_neg);
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            opd_d   = is_div ? mag_b : mag_a;
            prod_d  = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            cnt_d   = CNTW'(XLEN);
            state_d = S_CALC;
          end
        end else if (InValid) begin
          op_d    = MDOp;
          a_d     = SrcA;
          b_d     = SrcB;
          start_d = 1'b1;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          prod_d = step_next;
          cnt_d  = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            result_d = final_res;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (flush || OutReady)
          state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opd_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opd_q    <= opd_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign InReady  = (state_q == S_IDLE) && !start_q;
  assign OutValid = (state_q == S_DONE);
  assign Busy     = (state_q != S_IDLE);
  assign Result   = result_q;
  assign Zero     = (result_q == '0);
  assign Negative = result_q[XLEN-1];

endmodule
